// File: rtl/edge_pulse_gen_pkg.sv
// Purpose    : shared types and defaults for the edge pulse generator.
// Latency    : n/a (declarations only).
// Backpressure: n/a; the generator has no backpressure, start is dropped while busy.
// Contents   : state_t FSM encoding, CNT_W_DEFAULT counter/field width.
package edge_pulse_gen_pkg;

   localparam int CNT_W_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2,
      FIN  = 2'd3
   } state_t;

endpackage

// File: rtl/edge_pulse_gen_if.sv
// Purpose    : command/config and waveform signals between a requester and edge_pulse_gen.
// Latency    : n/a (wires only).
// Backpressure: none; start is only honoured while busy=0.
// Ports      : master drives start/high_len/low_len/num_pulses (and abort when
//              EDGE_PULSE_GEN_ABORT_EN is defined) and receives dout/busy/done;
//              slave is the generator side.
interface edge_pulse_gen_if
   import edge_pulse_gen_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEFAULT
) ();

   logic             start;
   logic [CNT_W-1:0] high_len;
   logic [CNT_W-1:0] low_len;
   logic [CNT_W-1:0] num_pulses;
`ifdef EDGE_PULSE_GEN_ABORT_EN
   logic             abort;
`endif
   logic             dout;
   logic             busy;
   logic             done;

`ifdef EDGE_PULSE_GEN_ABORT_EN
   modport master (
      output start, high_len, low_len, num_pulses, abort,
      input  dout, busy, done
   );
   modport slave (
      input  start, high_len, low_len, num_pulses, abort,
      output dout, busy, done
   );
`else
   modport master (
      output start, high_len, low_len, num_pulses,
      input  dout, busy, done
   );
   modport slave (
      input  start, high_len, low_len, num_pulses,
      output dout, busy, done
   );
`endif

endinterface

// File: rtl/edge_gen_cnt.sv
// Purpose    : loadable down-counter with zero flag; times phases and counts pulses.
// Latency    : load/decrement visible 1 cycle after the edge; zero is decoded from the register.
// Backpressure: none; en at zero holds the count (no wrap-around).
// Ports      : clk, rst (sync, active-high), load + load_val, en, zero.
module edge_gen_cnt #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   output logic             zero
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q;

   // load has priority so a phase can be reloaded in the cycle the previous one ends
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (en && (cnt_q != '0)) begin
         cnt_q <= cnt_q - ONE;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/edge_pulse_gen.sv
// Purpose    : on a one-cycle start, emits num_pulses high pulses of high_len cycles separated by low_len-cycle gaps on dout.
// Latency    : dout/busy rise 1 cycle after start; done is a 1-cycle strobe on the first 0 cycle after the last pulse.
// Backpressure: none; start while busy (or during the done cycle) is dropped, not queued.
// Ports      : clk, rst (sync, active-high), bus (edge_pulse_gen_if.slave: start, high_len,
//              low_len, num_pulses, dout, busy, done). Defining EDGE_PULSE_GEN_ABORT_EN adds
//              bus.abort, which returns any running train to IDLE without a done strobe.
module edge_pulse_gen
   import edge_pulse_gen_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   edge_pulse_gen_if.slave bus
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   // lengths of 0 behave as 1; counters hold "cycles remaining minus one"
   function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] len);
      return (len == '0) ? '0 : (len - ONE);
   endfunction

   state_t           state_q, state_d;
   logic             dout_q, dout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   // set when an empty train (num_pulses=0) enters FIN: that first FIN cycle shows
   // busy=1, the second one carries done
   logic             hold_q, hold_d;

   logic [CNT_W-1:0] hi_m1_q;
   logic [CNT_W-1:0] lo_m1_q;
   logic             cfg_ld;

   logic             ph_ld, ph_en, ph_zero;
   logic [CNT_W-1:0] ph_val;
   logic             pc_ld, pc_en, pc_zero;
   logic [CNT_W-1:0] pc_val;

   edge_gen_cnt #(.CNT_W(CNT_W)) u_phase_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (ph_ld),
      .load_val (ph_val),
      .en       (ph_en),
      .zero     (ph_zero)
   );

   // holds pulses remaining after the current one
   edge_gen_cnt #(.CNT_W(CNT_W)) u_pulse_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (pc_ld),
      .load_val (pc_val),
      .en       (pc_en),
      .zero     (pc_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         hi_m1_q <= '0;
         lo_m1_q <= '0;
      end else if (cfg_ld) begin
         hi_m1_q <= len_m1(bus.high_len);
         lo_m1_q <= len_m1(bus.low_len);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         dout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hold_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dout_q  <= dout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         hold_q  <= hold_d;
      end
   end

   // Outputs are computed for the state being entered and registered with it,
   // so dout/busy/done always describe the cycle the FSM is in.
   always_comb begin
      state_d = state_q;
      dout_d  = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      hold_d  = 1'b0;
      cfg_ld  = 1'b0;
      ph_ld   = 1'b0;
      ph_en   = 1'b0;
      ph_val  = hi_m1_q;
      pc_ld   = 1'b0;
      pc_en   = 1'b0;
      pc_val  = '0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (bus.num_pulses != '0) begin
                  state_d = HIGH;
                  dout_d  = 1'b1;
                  busy_d  = 1'b1;
                  cfg_ld  = 1'b1;
                  ph_ld   = 1'b1;
                  ph_val  = len_m1(bus.high_len);
                  pc_ld   = 1'b1;
                  pc_val  = bus.num_pulses - ONE;
               end else begin
                  state_d = FIN;
                  busy_d  = 1'b1;
                  hold_d  = 1'b1;
               end
            end
         end

         HIGH: begin
            if (!ph_zero) begin
               dout_d = 1'b1;
               busy_d = 1'b1;
               ph_en  = 1'b1;
            end else if (pc_zero) begin
               // last pulse: no trailing gap, done lands on the first low cycle
               state_d = FIN;
               done_d  = 1'b1;
            end else begin
               state_d = LOW;
               busy_d  = 1'b1;
               ph_ld   = 1'b1;
               ph_val  = lo_m1_q;
               pc_en   = 1'b1;
            end
         end

         LOW: begin
            if (!ph_zero) begin
               busy_d = 1'b1;
               ph_en  = 1'b1;
            end else begin
               state_d = HIGH;
               dout_d  = 1'b1;
               busy_d  = 1'b1;
               ph_ld   = 1'b1;
               ph_val  = hi_m1_q;
            end
         end

         FIN: begin
            if (hold_q) begin
               done_d = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

`ifdef EDGE_PULSE_GEN_ABORT_EN
      // abort is ignored in IDLE, which lets a simultaneous start win
      if ((state_q != IDLE) && bus.abort) begin
         state_d = IDLE;
         dout_d  = 1'b0;
         busy_d  = 1'b0;
         done_d  = 1'b0;
         hold_d  = 1'b0;
         cfg_ld  = 1'b0;
         ph_ld   = 1'b0;
         ph_en   = 1'b0;
         pc_ld   = 1'b0;
         pc_en   = 1'b0;
      end
`endif
   end

   assign bus.dout = dout_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule

// File: tb/tb_edge_pulse_gen.sv
// Purpose    : self-checking bench for edge_pulse_gen; a waveform scoreboard predicts {dout,busy,done} every cycle.
// Latency    : expectations are queued when stimulus is driven and compared one edge later.
// Backpressure: n/a; the bench pokes start at arbitrary times and the model decides acceptance.
module tb_edge_pulse_gen;

   import edge_pulse_gen_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   edge_pulse_gen_if #(.CNT_W(8)) bus ();

   edge_pulse_gen #(.CNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   // expected {dout,busy,done} per future cycle of a train still to play out
   logic [2:0] plan_q[$];
   // scoreboard: expectation for the cycle after the current edge
   logic [2:0] exp_q[$];
   logic [2:0] cur_exp = 3'b000;

   int   pos_cnt = 0;
   int   neg_cnt = 0;
   logic prev_dout = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic push_train(input logic [7:0] h, input logic [7:0] l, input logic [7:0] n);
      int hc = (h == 8'd0) ? 1 : int'(h);
      int lc = (l == 8'd0) ? 1 : int'(l);
      if (n == 8'd0) begin
         plan_q.push_back(3'b010);
         plan_q.push_back(3'b001);
      end else begin
         for (int p = 0; p < int'(n); p++) begin
            repeat (hc) plan_q.push_back(3'b110);
            if (p < int'(n) - 1) begin
               repeat (lc) plan_q.push_back(3'b010);
            end
         end
         plan_q.push_back(3'b001);
      end
   endtask

   // one clock cycle: drive inputs, predict the next cycle, sample after the edge
   task automatic cycle(input logic r, input logic st, input logic ab,
                        input logic [7:0] h, input logic [7:0] l, input logic [7:0] n);
      logic       idle;
      logic [2:0] got;
      logic [2:0] e;
      rst            = r;
      bus.start      = st;
      bus.high_len   = h;
      bus.low_len    = l;
      bus.num_pulses = n;
`ifdef EDGE_PULSE_GEN_ABORT_EN
      bus.abort      = ab;
`endif
      idle = (plan_q.size() == 0) && (cur_exp == 3'b000);
      if (r) begin
         plan_q.delete();
      end else if (idle) begin
         if (st) push_train(h, l, n);
      end else if (ab) begin
         plan_q.delete();
      end
      exp_q.push_back((plan_q.size() == 0) ? 3'b000 : plan_q.pop_front());

      @(posedge clk);
      #1;
      got = {bus.dout, bus.busy, bus.done};
      e   = exp_q.pop_front();
      check("wave", 32'(got), 32'(e));
      cur_exp = e;
      if (bus.dout && !prev_dout) pos_cnt++;
      if (!bus.dout && prev_dout) neg_cnt++;
      prev_dout = bus.dout;
   endtask

   task automatic idle_cycles(input int k);
      repeat (k) cycle(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
   endtask

   task automatic go(input logic [7:0] h, input logic [7:0] l, input logic [7:0] n);
      cycle(1'b0, 1'b1, 1'b0, h, l, n);
   endtask

   initial begin
      int guard;
      bus.start      = 1'b0;
      bus.high_len   = '0;
      bus.low_len    = '0;
      bus.num_pulses = '0;
`ifdef EDGE_PULSE_GEN_ABORT_EN
      bus.abort      = 1'b0;
`endif

      // reset, then quiet idle
      cycle(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
      cycle(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
      idle_cycles(10);

      // basic train, with edge counts seen by a downstream detector
      pos_cnt = 0;
      neg_cnt = 0;
      go(8'd2, 8'd3, 8'd3);
      idle_cycles(14);
      check("pos_edges", 32'(pos_cnt), 32'd3);
      check("neg_edges", 32'(neg_cnt), 32'd3);

      // zero lengths clamp to 1; zero pulses gives busy then done only
      go(8'd0, 8'd0, 8'd4);
      idle_cycles(10);
      pos_cnt = 0;
      go(8'd5, 8'd5, 8'd0);
      idle_cycles(4);
      check("empty_no_rise", 32'(pos_cnt), 32'd0);

      // start while busy ignored, start in done cycle ignored, start after done accepted
      go(8'd4, 8'd1, 8'd2);
      idle_cycles(2);
      go(8'd7, 8'd0, 8'd9);
      guard = 0;
      while (!bus.done && guard < 40) begin
         idle_cycles(1);
         guard++;
      end
      check("done_seen", 32'(bus.done), 32'd1);
      go(8'd3, 8'd3, 8'd3);
      go(8'd1, 8'd1, 8'd1);
      idle_cycles(4);

      // reset in the second HIGH phase aborts without done; fresh train afterwards
      go(8'd3, 8'd2, 8'd3);
      idle_cycles(6);
      cycle(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
      idle_cycles(5);
      go(8'd1, 8'd2, 8'd2);
      idle_cycles(8);

`ifdef EDGE_PULSE_GEN_ABORT_EN
      // abort during LOW of a 5-pulse train; abort+start in IDLE starts a train
      go(8'd2, 8'd3, 8'd5);
      idle_cycles(3);
      cycle(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
      idle_cycles(8);
      cycle(1'b0, 1'b1, 1'b1, 8'd2, 8'd1, 8'd2);
      idle_cycles(10);
`endif

      // random trains with random start pokes at arbitrary phases
      for (int k = 0; k < 8; k++) begin
         go(8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 8'($urandom_range(0, 4)));
         for (int j = 0; j < 30; j++) begin
            if ($urandom_range(0, 4) == 0) begin
               go(8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 8'($urandom_range(0, 4)));
            end else begin
               idle_cycles(1);
            end
         end
      end
      idle_cycles(40);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
